// File: rtl/lif_mem_ctrl.sv
// Membrane-state owner for one LIF neuron array: reads V[t-1] alongside each incoming delta,
// writes the returned V[t] back, and tags every returned spike with its neuron index and timestep.
`timescale 1ns/1ps
module lif_mem_ctrl #(
   parameter int ADD9_ALL_BITS = 16,
   parameter int NEURON_NUM    = 256,
   parameter int TIME_STEP     = 4,
   parameter int IDX_W         = $clog2(NEURON_NUM),
   parameter int T_W           = $clog2(TIME_STEP) + 1
) (
   input  logic                     s_clk,
   input  logic                     s_rst,
   input  logic                     i_start,
   input  logic [ADD9_ALL_BITS-1:0] i_delta_mem,
   input  logic                     i_delta_valid,
   output logic [ADD9_ALL_BITS-1:0] o_lif_delta,
   output logic [ADD9_ALL_BITS-1:0] o_lif_pre,
   output logic                     o_lif_valid,
   input  logic [ADD9_ALL_BITS-1:0] i_lif_nxt_mem,
   input  logic                     i_lif_spike,
   input  logic                     i_lif_valid,
   output logic                     o_spike,
   output logic [IDX_W-1:0]         o_spike_idx,
   output logic [T_W-1:0]           o_spike_t,
   output logic                     o_spike_valid,
   output logic                     o_frame_done,
   output logic                     o_busy
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURON_NUM - 1);
   localparam logic [T_W-1:0]   LAST_T   = T_W'(TIME_STEP - 1);

   state_t                   state;
   logic [IDX_W-1:0]         rd_idx;
   logic [IDX_W-1:0]         wr_idx;
   logic [T_W-1:0]           rd_t;
   logic [T_W-1:0]           wr_t;
   logic                     rd_done;
   logic                     pre_zero;
   logic [ADD9_ALL_BITS-1:0] mem [NEURON_NUM];
   logic [ADD9_ALL_BITS-1:0] rd_data;
   logic                     rd_fire;
   logic                     wr_fire;

   // Reset cancels any access presented in the same cycle, so in-flight data is discarded.
   assign rd_fire = !s_rst && (state == RUN) && i_delta_valid && !rd_done;
   assign wr_fire = !s_rst && (state == RUN) && i_lif_valid;

   // NOTE: the membrane array has no reset; timestep-0 reads are masked to zero instead,
   // which keeps this a plain dual-port RAM with a registered read port.
   always_ff @(posedge s_clk) begin
      if (wr_fire) mem[wr_idx] <= i_lif_nxt_mem;
      if (rd_fire) rd_data <= mem[rd_idx];
   end

   // V[-1] is the reset potential 0, so the stale RAM word is replaced on the first timestep.
   assign o_lif_pre = (o_lif_valid && !pre_zero) ? rd_data : '0;

   // NOTE: every register here uses <=, so all branches see the pre-edge values of the counters.
   always_ff @(posedge s_clk) begin
      if (s_rst) begin
         state         <= IDLE;
         rd_idx        <= '0;
         rd_t          <= '0;
         wr_idx        <= '0;
         wr_t          <= '0;
         rd_done       <= 1'b0;
         pre_zero      <= 1'b0;
         o_lif_delta   <= '0;
         o_lif_valid   <= 1'b0;
         o_spike       <= 1'b0;
         o_spike_idx   <= '0;
         o_spike_t     <= '0;
         o_spike_valid <= 1'b0;
         o_frame_done  <= 1'b0;
         o_busy        <= 1'b0;
      end else begin
         o_lif_valid   <= rd_fire;
         o_spike_valid <= wr_fire;
         o_frame_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  state   <= RUN;
                  o_busy  <= 1'b1;
                  rd_idx  <= '0;
                  rd_t    <= '0;
                  wr_idx  <= '0;
                  wr_t    <= '0;
                  rd_done <= 1'b0;
               end
            end
            RUN: begin
               if (rd_fire) begin
                  o_lif_delta <= i_delta_mem;
                  pre_zero    <= (rd_t == '0);
                  if (rd_idx == LAST_IDX) begin
                     rd_idx <= '0;
                     // Deltas past the last neuron of the last timestep are not accepted.
                     if (rd_t == LAST_T) rd_done <= 1'b1;
                     else                rd_t    <= rd_t + 1'b1;
                  end else begin
                     rd_idx <= rd_idx + 1'b1;
                  end
               end
               if (wr_fire) begin
                  o_spike     <= i_lif_spike;
                  o_spike_idx <= wr_idx;
                  o_spike_t   <= wr_t;
                  if (wr_idx == LAST_IDX) begin
                     wr_idx <= '0;
                     if (wr_t == LAST_T) begin
                        o_frame_done <= 1'b1;
                        o_busy       <= 1'b0;
                        state        <= IDLE;
                     end else begin
                        wr_t <= wr_t + 1'b1;
                     end
                  end else begin
                     wr_idx <= wr_idx + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lif_mem_ctrl.sv
// Directed bench for lif_mem_ctrl with a 1-cycle LIF neuron model, NEURON_NUM=4, TIME_STEP=2.
`timescale 1ns/1ps
module tb_lif_mem_ctrl;

   localparam int W  = 16;
   localparam int N  = 4;
   localparam int T  = 2;
   localparam int IW = 2;
   localparam int TW = 2;
   localparam int NF = N * T;
   localparam logic signed [15:0] TH = 16'sd100;

   logic          s_clk = 1'b0;
   logic          s_rst;
   logic          i_start;
   logic [W-1:0]  i_delta_mem;
   logic          i_delta_valid;
   logic [W-1:0]  o_lif_delta;
   logic [W-1:0]  o_lif_pre;
   logic          o_lif_valid;
   logic [W-1:0]  i_lif_nxt_mem;
   logic          i_lif_spike;
   logic          i_lif_valid;
   logic          o_spike;
   logic [IW-1:0] o_spike_idx;
   logic [TW-1:0] o_spike_t;
   logic          o_spike_valid;
   logic          o_frame_done;
   logic          o_busy;

   lif_mem_ctrl #(.ADD9_ALL_BITS(W), .NEURON_NUM(N), .TIME_STEP(T)) dut (
      .s_clk(s_clk), .s_rst(s_rst), .i_start(i_start),
      .i_delta_mem(i_delta_mem), .i_delta_valid(i_delta_valid),
      .o_lif_delta(o_lif_delta), .o_lif_pre(o_lif_pre), .o_lif_valid(o_lif_valid),
      .i_lif_nxt_mem(i_lif_nxt_mem), .i_lif_spike(i_lif_spike), .i_lif_valid(i_lif_valid),
      .o_spike(o_spike), .o_spike_idx(o_spike_idx), .o_spike_t(o_spike_t),
      .o_spike_valid(o_spike_valid), .o_frame_done(o_frame_done), .o_busy(o_busy)
   );

   always #5 s_clk = ~s_clk;

   typedef struct packed {logic [15:0] delta; logic [15:0] pre;} lif_rec_t;
   typedef struct packed {logic spike; logic [IW-1:0] idx; logic [TW-1:0] t; logic done; int cyc;} spk_rec_t;

   lif_rec_t    lif_q[$];
   spk_rec_t    spk_q[$];
   int          dcyc_q[$];
   int          cyc = 0;
   int          done_cnt = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] d_tab[NF];
   logic [15:0] pre_tab[NF];
   logic        spk_tab[NF];

   // LIF neuron model: v = (delta + pre) >>> 1; spike and store 0 when v >= TH.
   function automatic logic [16:0] lif_f(input logic [15:0] d, input logic [15:0] p);
      logic signed [16:0] s;
      logic signed [15:0] v;
      logic               sp;
      s  = $signed({d[15], d}) + $signed({p[15], p});
      v  = s[16:1];
      sp = (v >= TH) && (v >= 16'sd0);
      return {sp, sp ? 16'h0000 : 16'(v)};
   endfunction

   always @(posedge s_clk) begin
      cyc <= cyc + 1;
      if (s_rst) begin
         i_lif_valid   <= 1'b0;
         i_lif_spike   <= 1'b0;
         i_lif_nxt_mem <= '0;
      end else begin
         i_lif_valid                  <= o_lif_valid;
         {i_lif_spike, i_lif_nxt_mem} <= lif_f(o_lif_delta, o_lif_pre);
      end
   end

   always @(negedge s_clk) begin
      if (o_lif_valid)   lif_q.push_back('{o_lif_delta, o_lif_pre});
      if (o_spike_valid) spk_q.push_back('{o_spike, o_spike_idx, o_spike_t, o_frame_done, cyc});
      if (o_frame_done)  done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge s_clk);
      #1;
   endtask

   task automatic send(input logic [15:0] d, input logic st, input bit rec);
      i_delta_valid = 1'b1;
      i_delta_mem   = d;
      i_start       = st;
      if (rec) dcyc_q.push_back(cyc);
      step();
      i_delta_valid = 1'b0;
      i_start       = 1'b0;
   endtask

   // The delta offered together with i_start must be dropped.
   task automatic start_frame();
      i_start       = 1'b1;
      i_delta_valid = 1'b1;
      i_delta_mem   = 16'h0BAD;
      step();
      i_start       = 1'b0;
      i_delta_valid = 1'b0;
   endtask

   task automatic set_tab(input int i, input int d, input int p, input bit s);
      d_tab[i]   = 16'(d);
      pre_tab[i] = 16'(p);
      spk_tab[i] = s;
   endtask

   task automatic wait_done(input string name);
      int start_cnt;
      start_cnt = done_cnt;
      for (int k = 0; k < 40 && done_cnt == start_cnt; k++) step();
      check({name, "_done_seen"}, 32'(done_cnt - start_cnt), 32'd1);
      repeat (4) step();
   endtask

   task automatic check_outputs_zero(input string name);
      check({name, "_lif_valid"},   32'(o_lif_valid),   32'd0);
      check({name, "_lif_delta"},   32'(o_lif_delta),   32'd0);
      check({name, "_lif_pre"},     32'(o_lif_pre),     32'd0);
      check({name, "_spike_valid"}, 32'(o_spike_valid), 32'd0);
      check({name, "_spike"},       32'(o_spike),       32'd0);
      check({name, "_spike_idx"},   32'(o_spike_idx),   32'd0);
      check({name, "_spike_t"},     32'(o_spike_t),     32'd0);
      check({name, "_frame_done"},  32'(o_frame_done),  32'd0);
      check({name, "_busy"},        32'(o_busy),        32'd0);
   endtask

   task automatic check_frame(input string name);
      check({name, "_lif_count"},   32'(lif_q.size()), 32'(NF));
      check({name, "_spike_count"}, 32'(spk_q.size()), 32'(NF));
      for (int i = 0; i < NF; i++) begin
         if (i < lif_q.size()) begin
            check($sformatf("%s_delta%0d", name, i), 32'(lif_q[i].delta), 32'(d_tab[i]));
            check($sformatf("%s_pre%0d", name, i),   32'(lif_q[i].pre),   32'(pre_tab[i]));
         end
         if (i < spk_q.size() && i < dcyc_q.size()) begin
            check($sformatf("%s_spike%0d", name, i), 32'(spk_q[i].spike), 32'(spk_tab[i]));
            check($sformatf("%s_idx%0d", name, i),   32'(spk_q[i].idx),   32'(i % N));
            check($sformatf("%s_t%0d", name, i),     32'(spk_q[i].t),     32'(i / N));
            check($sformatf("%s_done%0d", name, i),  32'(spk_q[i].done),  32'(i == NF - 1));
            check($sformatf("%s_lat%0d", name, i),   32'(spk_q[i].cyc - dcyc_q[i]), 32'd3);
         end
      end
      check({name, "_busy_after"}, 32'(o_busy), 32'd0);
      lif_q.delete();
      spk_q.delete();
      dcyc_q.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      s_rst         = 1'b1;
      i_start       = 1'b0;
      i_delta_valid = 1'b0;
      i_delta_mem   = '0;
      repeat (3) step();
      check_outputs_zero("reset");
      s_rst = 1'b0;
      step();

      // Frame A: negative membranes leave stale nonzero words in RAM.
      for (int i = 0; i < N; i++) begin
         set_tab(i, -200, 0, 1'b0);
         set_tab(i + N, -200, -100, 1'b0);
      end
      start_frame();
      for (int i = 0; i < NF; i++) send(d_tab[i], 1'b0, 1'b1);
      wait_done("frA");
      check_frame("frA");

      // Frame B: t0 must ignore the stale -150; accumulation at t1; a 9th delta is ignored.
      for (int i = 0; i < N; i++) begin
         set_tab(i, 60, 0, 1'b0);
         set_tab(i + N, 60, 30, 1'b0);
      end
      start_frame();
      send(d_tab[0], 1'b0, 1'b1);
      check("frB_busy_run", 32'(o_busy), 32'd1);
      for (int i = 1; i < NF; i++) send(d_tab[i], 1'b0, 1'b1);
      send(16'd77, 1'b0, 1'b0);
      wait_done("frB");
      check_frame("frB");

      // Frame C: spike resets n0, n1 stores -4; i_start mid-frame has no effect.
      set_tab(0, 250, 0, 1'b1);
      set_tab(1, -8, 0, 1'b0);
      set_tab(2, 0, 0, 1'b0);
      set_tab(3, 0, 0, 1'b0);
      set_tab(4, 0, 0, 1'b0);
      set_tab(5, 0, -4, 1'b0);
      set_tab(6, 0, 0, 1'b0);
      set_tab(7, 0, 0, 1'b0);
      start_frame();
      for (int i = 0; i < NF; i++) send(d_tab[i], (i == 4), 1'b1);
      wait_done("frC");
      check_frame("frC");

      // Frame D: reset on the 3rd delta discards everything in flight.
      start_frame();
      send(16'd10, 1'b0, 1'b0);
      send(16'd20, 1'b0, 1'b0);
      s_rst         = 1'b1;
      i_delta_valid = 1'b1;
      i_delta_mem   = 16'd30;
      step();
      i_delta_valid = 1'b0;
      step();
      check_outputs_zero("midrst");
      s_rst = 1'b0;
      repeat (3) step();
      check("midrst_no_spikes", 32'(spk_q.size()), 32'd0);
      lif_q.delete();
      spk_q.delete();
      dcyc_q.delete();

      // Frame E: fresh frame after reset starts from V=0 with indices at 0.
      set_tab(0, 10, 0, 1'b0);
      set_tab(1, 20, 0, 1'b0);
      set_tab(2, 30, 0, 1'b0);
      set_tab(3, 40, 0, 1'b0);
      set_tab(4, 0, 5, 1'b0);
      set_tab(5, 0, 10, 1'b0);
      set_tab(6, 0, 15, 1'b0);
      set_tab(7, 0, 20, 1'b0);
      start_frame();
      for (int i = 0; i < NF; i++) send(d_tab[i], 1'b0, 1'b1);
      wait_done("frE");
      check_frame("frE");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
